// File: rtl/slot_sched_ctrl_if.sv
// Request, actuator and status signals of the three-slot color bay controller.
// The controller connects through the slave modport; pickup/dispatch/actuator models use master.
interface slot_sched_ctrl_if;
   logic       st_valid;
   logic [1:0] st_color;
   logic       st_ready;
   logic       rt_valid;
   logic [1:0] rt_color;
   logic       rt_ready;
   logic       act_cmd_valid;
   logic       act_cmd_op;
   logic [1:0] act_cmd_slot;
   logic       act_ready;
   logic       act_done;
   logic [1:0] pos1;
   logic [1:0] pos2;
   logic [1:0] pos3;
   logic       rsp_valid;
   logic [1:0] rsp_status;
   logic       busy;

   modport slave (
      input  st_valid, st_color, rt_valid, rt_color, act_ready, act_done,
      output st_ready, rt_ready, act_cmd_valid, act_cmd_op, act_cmd_slot,
      output pos1, pos2, pos3, rsp_valid, rsp_status, busy
   );

   modport master (
      output st_valid, st_color, rt_valid, rt_color, act_ready, act_done,
      input  st_ready, rt_ready, act_cmd_valid, act_cmd_op, act_cmd_slot,
      input  pos1, pos2, pos3, rsp_valid, rsp_status, busy
   );
endinterface

// File: rtl/slot_sched_ctrl.sv
// Sequencing controller for the three-slot color bay: arbitrates store/retrieve requests,
// drives the bay actuator and owns slot occupancy. Optional macro: TIMEOUT_RETRY_EN.
module slot_sched_ctrl #(
   parameter int unsigned MOVE_TIMEOUT = 255,
   parameter int unsigned TO_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   slot_sched_ctrl_if.slave bus_if,
   output logic [1:0]       state_o
);

   // Handshake rule for every valid/ready pair here: a transfer happens on a rising edge
   // where both valid and ready are high; ready never waits on anything but the valids.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   localparam logic [1:0]      ST_OK      = 2'b00;
   localparam logic [1:0]      ST_ST_REJ  = 2'b01;
   localparam logic [1:0]      ST_RT_MISS = 2'b10;
   localparam logic [1:0]      ST_TIMEOUT = 2'b11;
   localparam logic            PRIO_ST    = 1'b0;
   localparam logic            PRIO_RT    = 1'b1;
   localparam logic [TO_W-1:0] TO_LAST    = TO_W'(MOVE_TIMEOUT - 1);

   state_e          state_q, state_d;
   logic            prio_q, prio_d;
   logic            op_q, op_d;
   logic [1:0]      slot_q, slot_d;
   logic [1:0]      color_q, color_d;
   logic [1:0]      status_q, status_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic [1:0]      pos0_q, pos0_d;
   logic [1:0]      pos1_q, pos1_d;
   logic [1:0]      pos2_q, pos2_d;
`ifdef TIMEOUT_RETRY_EN
   logic            retry_q, retry_d;
`endif

   logic       st_rdy, rt_rdy;
   logic       st_acc, rt_acc;
   logic [2:0] free_vec;
   logic [2:0] st_hit;
   logic [2:0] rt_hit;
   logic [1:0] free_idx;
   logic [1:0] rt_idx;
   logic       st_reject;
   logic       rt_reject;

   always_comb begin
      st_rdy = (state_q == IDLE) && (!bus_if.rt_valid || (prio_q == PRIO_ST));
      rt_rdy = (state_q == IDLE) && (!bus_if.st_valid || (prio_q == PRIO_RT));
      st_acc = bus_if.st_valid && st_rdy;
      rt_acc = bus_if.rt_valid && rt_rdy;
   end

   // Slot lookups: lowest empty slot for stores, the slot holding the color for retrieves.
   always_comb begin
      free_vec = {pos2_q == 2'b00, pos1_q == 2'b00, pos0_q == 2'b00};
      st_hit   = {pos2_q == bus_if.st_color, pos1_q == bus_if.st_color,
                  pos0_q == bus_if.st_color};
      rt_hit   = {pos2_q == bus_if.rt_color, pos1_q == bus_if.rt_color,
                  pos0_q == bus_if.rt_color};

      if (free_vec[0]) begin
         free_idx = 2'd0;
      end else if (free_vec[1]) begin
         free_idx = 2'd1;
      end else begin
         free_idx = 2'd2;
      end

      if (rt_hit[0]) begin
         rt_idx = 2'd0;
      end else if (rt_hit[1]) begin
         rt_idx = 2'd1;
      end else begin
         rt_idx = 2'd2;
      end

      st_reject = (bus_if.st_color == 2'b00) || (|st_hit) || !(|free_vec);
      rt_reject = (bus_if.rt_color == 2'b00) || !(|rt_hit);
   end

   always_comb begin
      state_d  = state_q;
      prio_d   = prio_q;
      op_d     = op_q;
      slot_d   = slot_q;
      color_d  = color_q;
      status_d = status_q;
      cnt_d    = cnt_q;
      pos0_d   = pos0_q;
      pos1_d   = pos1_q;
      pos2_d   = pos2_q;
`ifdef TIMEOUT_RETRY_EN
      retry_d  = retry_q;
`endif

      // Contention only exists when both streams present; the loser gets the next turn.
      if (bus_if.st_valid && bus_if.rt_valid && (st_acc || rt_acc)) begin
         prio_d = ~prio_q;
      end

      case (state_q)
         IDLE: begin
            if (st_acc) begin
               op_d    = 1'b0;
               color_d = bus_if.st_color;
`ifdef TIMEOUT_RETRY_EN
               retry_d = 1'b0;
`endif
               if (st_reject) begin
                  status_d = ST_ST_REJ;
                  state_d  = RESP;
               end else begin
                  slot_d  = free_idx;
                  state_d = ISSUE;
               end
            end else if (rt_acc) begin
               op_d    = 1'b1;
               color_d = bus_if.rt_color;
`ifdef TIMEOUT_RETRY_EN
               retry_d = 1'b0;
`endif
               if (rt_reject) begin
                  status_d = ST_RT_MISS;
                  state_d  = RESP;
               end else begin
                  slot_d  = rt_idx;
                  state_d = ISSUE;
               end
            end
         end

         ISSUE: begin
            if (bus_if.act_ready) begin
               cnt_d   = '0;
               state_d = WAIT;
            end
         end

         WAIT: begin
            cnt_d = cnt_q + TO_W'(1);
            // A completion in the final timeout cycle still counts as success.
            if (bus_if.act_done) begin
               case (slot_q)
                  2'd0:    pos0_d = op_q ? 2'b00 : color_q;
                  2'd1:    pos1_d = op_q ? 2'b00 : color_q;
                  default: pos2_d = op_q ? 2'b00 : color_q;
               endcase
               status_d = ST_OK;
               state_d  = RESP;
            end else if (cnt_q == TO_LAST) begin
`ifdef TIMEOUT_RETRY_EN
               if (!retry_q) begin
                  retry_d = 1'b1;
                  state_d = ISSUE;
               end else begin
                  status_d = ST_TIMEOUT;
                  state_d  = RESP;
               end
`else
               status_d = ST_TIMEOUT;
               state_d  = RESP;
`endif
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         prio_q   <= PRIO_ST;
         op_q     <= 1'b0;
         slot_q   <= 2'd0;
         color_q  <= 2'b00;
         status_q <= ST_OK;
         cnt_q    <= '0;
         pos0_q   <= 2'b00;
         pos1_q   <= 2'b00;
         pos2_q   <= 2'b00;
`ifdef TIMEOUT_RETRY_EN
         retry_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         prio_q   <= prio_d;
         op_q     <= op_d;
         slot_q   <= slot_d;
         color_q  <= color_d;
         status_q <= status_d;
         cnt_q    <= cnt_d;
         pos0_q   <= pos0_d;
         pos1_q   <= pos1_d;
         pos2_q   <= pos2_d;
`ifdef TIMEOUT_RETRY_EN
         retry_q  <= retry_d;
`endif
      end
   end

   always_comb begin
      bus_if.st_ready      = st_rdy;
      bus_if.rt_ready      = rt_rdy;
      bus_if.act_cmd_valid = (state_q == ISSUE);
      bus_if.act_cmd_op    = op_q;
      bus_if.act_cmd_slot  = slot_q;
      bus_if.pos1          = pos0_q;
      bus_if.pos2          = pos1_q;
      bus_if.pos3          = pos2_q;
      bus_if.rsp_valid     = (state_q == RESP);
      bus_if.rsp_status    = status_q;
      bus_if.busy          = (state_q != IDLE);
      state_o              = state_q;
   end

endmodule

// File: tb/tb_slot_sched_ctrl.sv
// Bench for slot_sched_ctrl: table of store/retrieve vectors with a status scoreboard,
// plus hand sequences for timeout, reset-in-flight and arbitration.
module tb_slot_sched_ctrl;

   localparam int unsigned TO = 4;
`ifdef TIMEOUT_RETRY_EN
   localparam int TO_NCMD = 2;
   localparam int TO_LAT  = 3 + 2 * TO;
`else
   localparam int TO_NCMD = 1;
   localparam int TO_LAT  = 2 + TO;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] state_dbg;

   slot_sched_ctrl_if bus_if();

   slot_sched_ctrl #(.MOVE_TIMEOUT(TO), .TO_W(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus_if  (bus_if),
      .state_o (state_dbg)
   );

   always #5 clk = ~clk;

   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   int         rsp_cnt = 0;
   int         last_rsp_cyc = 0;
   logic [1:0] exp_q[$];
   logic [2:0] cmd_log[$];
   logic [1:0] mon_exp;
   bit         ready_en = 1'b1;
   bit         done_en = 1'b1;
   int         done_delay = 2;
   int         done_cnt = 0;

   typedef struct {
      bit         is_st;
      logic [1:0] color;
      logic [1:0] status;
      int         ncmd;
      logic [1:0] slot;
      logic [1:0] p1;
      logic [1:0] p2;
      logic [1:0] p3;
   } vec_t;

   vec_t vec[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Response monitor: every pulse must match the oldest expected status.
   initial forever begin
      @(negedge clk);
      if (bus_if.rsp_valid === 1'b1) begin
         rsp_cnt++;
         last_rsp_cyc = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: status %b with nothing expected", bus_if.rsp_status);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("rsp_status", 32'(bus_if.rsp_status), 32'(mon_exp));
         end
      end
   end

   // Actuator model: ready follows ready_en, done pulses done_delay cycles after a command.
   initial begin
      bus_if.act_ready = 1'b0;
      bus_if.act_done  = 1'b0;
      forever begin
         @(negedge clk);
         bus_if.act_done = 1'b0;
         if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) bus_if.act_done = 1'b1;
         end
         bus_if.act_ready = ready_en;
         if (bus_if.act_cmd_valid === 1'b1 && bus_if.act_ready) begin
            cmd_log.push_back({bus_if.act_cmd_op, bus_if.act_cmd_slot});
            if (done_en) done_cnt = done_delay;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic drive_req(input bit is_st, input logic [1:0] color, input bit push,
                            input logic [1:0] exp, output int acc_cyc);
      bit ok;
      ok = 1'b0;
      acc_cyc = 0;
      @(negedge clk);
      if (is_st) begin
         bus_if.st_valid = 1'b1;
         bus_if.st_color = color;
      end else begin
         bus_if.rt_valid = 1'b1;
         bus_if.rt_color = color;
      end
      for (int i = 0; i < 100; i++) begin
         #1;
         if ((is_st && bus_if.st_ready) || (!is_st && bus_if.rt_ready)) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) begin
         acc_cyc = cyc;
         if (push) exp_q.push_back(exp);
      end else begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: ready %b required 1", 1'b0);
      end
      @(posedge clk);
      #1;
      bus_if.st_valid = 1'b0;
      bus_if.rt_valid = 1'b0;
   endtask

   task automatic run_op(input bit is_st, input logic [1:0] color, input logic [1:0] status,
                         input int ncmd, input logic [1:0] slot, input int lat,
                         input logic [1:0] p1, input logic [1:0] p2, input logic [1:0] p3);
      int base;
      int acc;
      bit got;
      base = rsp_cnt;
      got = 1'b0;
      cmd_log.delete();
      drive_req(is_st, color, 1'b1, status, acc);
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         #2;
         if (rsp_cnt != base) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL rsp_timeout: no response, required status %b", status);
         exp_q.delete();
      end else begin
         chk("latency", 32'(last_rsp_cyc - acc), 32'(lat));
      end
      chk("cmd_count", 32'(cmd_log.size()), 32'(ncmd));
      for (int k = 0; k < cmd_log.size(); k++) begin
         chk("cmd_op", 32'(cmd_log[k][2]), is_st ? 32'd0 : 32'd1);
         chk("cmd_slot", 32'(cmd_log[k][1:0]), 32'(slot));
      end
      chk("pos1", 32'(bus_if.pos1), 32'(p1));
      chk("pos2", 32'(bus_if.pos2), 32'(p2));
      chk("pos3", 32'(bus_if.pos3), 32'(p3));
      repeat (8) @(negedge clk);
   endtask

   int  acc_tmp;
   int  base_tmp;
   int  grants;
   bit  seen;

   initial begin
      vec[0]  = '{1'b1, 2'b01, 2'b00, 1, 2'd0, 2'b01, 2'b00, 2'b00};
      vec[1]  = '{1'b1, 2'b10, 2'b00, 1, 2'd1, 2'b01, 2'b10, 2'b00};
      vec[2]  = '{1'b1, 2'b11, 2'b00, 1, 2'd2, 2'b01, 2'b10, 2'b11};
      vec[3]  = '{1'b1, 2'b10, 2'b01, 0, 2'd0, 2'b01, 2'b10, 2'b11};
      vec[4]  = '{1'b1, 2'b00, 2'b01, 0, 2'd0, 2'b01, 2'b10, 2'b11};
      vec[5]  = '{1'b0, 2'b11, 2'b00, 1, 2'd2, 2'b01, 2'b10, 2'b00};
      vec[6]  = '{1'b0, 2'b11, 2'b10, 0, 2'd0, 2'b01, 2'b10, 2'b00};
      vec[7]  = '{1'b0, 2'b10, 2'b00, 1, 2'd1, 2'b01, 2'b00, 2'b00};
      vec[8]  = '{1'b0, 2'b00, 2'b10, 0, 2'd0, 2'b01, 2'b00, 2'b00};
      vec[9]  = '{1'b1, 2'b11, 2'b00, 1, 2'd1, 2'b01, 2'b11, 2'b00};
      vec[10] = '{1'b1, 2'b10, 2'b00, 1, 2'd2, 2'b01, 2'b11, 2'b10};
      vec[11] = '{1'b0, 2'b01, 2'b00, 1, 2'd0, 2'b00, 2'b11, 2'b10};
      vec[12] = '{1'b1, 2'b11, 2'b01, 0, 2'd0, 2'b00, 2'b11, 2'b10};
      vec[13] = '{1'b1, 2'b01, 2'b00, 1, 2'd0, 2'b01, 2'b11, 2'b10};

      rst = 1'b1;
      bus_if.st_valid = 1'b0;
      bus_if.st_color = 2'b00;
      bus_if.rt_valid = 1'b0;
      bus_if.rt_color = 2'b00;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_pos1", 32'(bus_if.pos1), 32'd0);
      chk("rst_pos2", 32'(bus_if.pos2), 32'd0);
      chk("rst_pos3", 32'(bus_if.pos3), 32'd0);
      chk("rst_busy", 32'(bus_if.busy), 32'd0);
      chk("rst_cmd_valid", 32'(bus_if.act_cmd_valid), 32'd0);
      chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
      chk("rst_rsp_status", 32'(bus_if.rsp_status), 32'd0);
      chk("rst_st_ready", 32'(bus_if.st_ready), 32'd1);
      chk("rst_rt_ready", 32'(bus_if.rt_ready), 32'd1);

      for (int i = 0; i < 14; i++) begin
         run_op(vec[i].is_st, vec[i].color, vec[i].status, vec[i].ncmd, vec[i].slot,
                (vec[i].ncmd > 0) ? 4 : 1, vec[i].p1, vec[i].p2, vec[i].p3);
      end

      // Bay is 01/11/10: timeout with no completion, completion on the last allowed
      // cycle, and a completion one cycle too late.
      done_en = 1'b0;
      run_op(1'b0, 2'b11, 2'b11, TO_NCMD, 2'd1, TO_LAT, 2'b01, 2'b11, 2'b10);
      done_en = 1'b1;
      done_delay = TO;
      run_op(1'b0, 2'b11, 2'b00, 1, 2'd1, 2 + TO, 2'b01, 2'b00, 2'b10);
      done_delay = TO + 1;
      run_op(1'b1, 2'b11, 2'b11, TO_NCMD, 2'd1, TO_LAT, 2'b01, 2'b00, 2'b10);
      done_delay = 2;

      // Reset while an operation waits for the actuator.
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      run_op(1'b1, 2'b01, 2'b00, 1, 2'd0, 4, 2'b01, 2'b00, 2'b00);
      done_delay = 3;
      drive_req(1'b1, 2'b10, 1'b0, 2'b00, acc_tmp);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (state_dbg == 2'd2) begin
            seen = 1'b1;
            break;
         end
      end
      chk("reached_wait", 32'(seen), 32'd1);
      chk("pos1_before_rst", 32'(bus_if.pos1), 32'd1);
      base_tmp = rsp_cnt;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      #1;
      chk("midrst_pos1", 32'(bus_if.pos1), 32'd0);
      chk("midrst_pos2", 32'(bus_if.pos2), 32'd0);
      chk("midrst_pos3", 32'(bus_if.pos3), 32'd0);
      chk("midrst_busy", 32'(bus_if.busy), 32'd0);
      chk("midrst_cmd_valid", 32'(bus_if.act_cmd_valid), 32'd0);
      chk("midrst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
      repeat (6) @(negedge clk);
      #1;
      chk("late_done_pos1", 32'(bus_if.pos1), 32'd0);
      chk("late_done_pos2", 32'(bus_if.pos2), 32'd0);
      chk("late_done_busy", 32'(bus_if.busy), 32'd0);
      chk("no_rsp_after_rst", 32'(rsp_cnt - base_tmp), 32'd0);
      done_delay = 2;

      // Both streams held valid from reset: grants must alternate starting with store.
      @(negedge clk);
      rst = 1'b1;
      bus_if.st_valid = 1'b1;
      bus_if.st_color = 2'b11;
      bus_if.rt_valid = 1'b1;
      bus_if.rt_color = 2'b11;
      cmd_log.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      base_tmp = rsp_cnt;
      grants = 0;
      for (int i = 0; i < 200 && grants < 4; i++) begin
         @(negedge clk);
         #1;
         if (bus_if.st_ready && bus_if.rt_ready) begin
            checks++;
            errors++;
            $display("FAIL dual_grant: both ready with both valid");
         end else if (bus_if.st_ready || bus_if.rt_ready) begin
            chk("grant_order", 32'(bus_if.rt_ready), 32'(grants % 2));
            chk("rsp_before_grant", 32'(rsp_cnt - base_tmp), 32'(grants));
            exp_q.push_back(2'b00);
            grants++;
         end
      end
      chk("grant_count", 32'(grants), 32'd4);
      @(posedge clk);
      #1;
      bus_if.st_valid = 1'b0;
      bus_if.rt_valid = 1'b0;
      for (int i = 0; i < 40 && (rsp_cnt - base_tmp) < 4; i++) @(negedge clk);
      #2;
      chk("arb_rsp_count", 32'(rsp_cnt - base_tmp), 32'd4);
      chk("arb_cmd_count", 32'(cmd_log.size()), 32'd4);
      for (int k = 0; k < cmd_log.size(); k++) begin
         chk("arb_cmd_op", 32'(cmd_log[k][2]), 32'(k % 2));
         chk("arb_cmd_slot", 32'(cmd_log[k][1:0]), 32'd0);
      end
      chk("arb_pos1", 32'(bus_if.pos1), 32'd0);
      repeat (6) @(negedge clk);

      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/slot_sched_ctrl.md
Name: slot_sched_ctrl

Overview:
Sequencing controller for the rover's three-slot color storage bay.
- Accepts store and retrieve requests (colors R=01, G=10, B=11) from the pickup and dispatch logic over valid/ready handshakes.
- Arbitrates between the two request streams and issues place/pick commands to the bay actuator.
- Maintains the authoritative slot occupancy on pos1..pos3 and reports one status pulse per request.

Parameters:
- MOVE_TIMEOUT, 255: cycles allowed in WAIT for act_done before the operation is abandoned; legal range 1..65535.
- TO_W, 16: width of the timeout counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- st_valid  in  1  store request valid
- st_color  in  2  color to store
- st_ready  out  1  store request accepted this cycle when high with st_valid
- rt_valid  in  1  retrieve request valid
- rt_color  in  2  color to retrieve
- rt_ready  out  1  retrieve request accepted this cycle when high with rt_valid
- act_cmd_valid  out  1  actuator command valid
- act_cmd_op  out  1  0 = place into slot, 1 = pick from slot
- act_cmd_slot  out  2  target slot index 0..2 (pos1..pos3)
- act_ready  in  1  actuator accepts command
- act_done  in  1  one-cycle pulse, actuator finished the accepted command
- pos1, pos2, pos3  out  2 each  slot contents, 00 = empty
- rsp_valid  out  1  one-cycle response pulse
- rsp_status  out  2  00 ok, 01 store rejected, 10 retrieve not found, 11 timeout
- busy  out  1  high whenever state != IDLE

Behaviour:

Reset (rst=1 at a clock edge):
- pos1..pos3 = 00, state = IDLE, act_cmd_valid = 0, rsp_valid = 0, rsp_status = 00, priority = store.
- Reset mid-operation abandons any issued command with no response and clears all slots.

Ready and arbitration:
- st_ready = IDLE & (!rt_valid | prio==store).
- rt_ready = IDLE & (!st_valid | prio==retrieve).
- The ready signals are combinational on the valids.
- prio flips after every cycle in which both valids are high and one request is granted. It is unchanged when only one valid is high.

States: IDLE, ISSUE, WAIT, RESP.

IDLE, on an accepted request (cycle N):
- Store is rejected with status 01 when: color is 00, the color is already present in any slot, or all slots are occupied.
- Retrieve is rejected with status 10 when: color is 00 or no slot holds the color.
- On reject, go to RESP; rsp_valid is high in cycle N+1.
- Otherwise latch op and slot, then go to ISSUE.
- Store slot = lowest-index empty slot. Retrieve slot = the unique slot holding the color.

ISSUE:
- act_cmd_valid = 1 with op/slot stable until act_ready = 1; then go to WAIT and clear the timeout counter.
- act_done in ISSUE is ignored.

WAIT:
- The counter increments each cycle.
- On act_done: store writes the latched color into the slot; retrieve writes 00. The slot updates at the same edge. Go to RESP with status 00.
- If the counter reaches MOVE_TIMEOUT without act_done: go to RESP with status 11 and leave slots unchanged.
- If act_done arrives in the same cycle the counter hits MOVE_TIMEOUT, done wins.

RESP:
- rsp_valid = 1 for exactly one cycle, then return to IDLE.
- No request is accepted in RESP.

Latency:
- Minimum accepted-to-response latency = 3 cycles plus actuator latency (ISSUE 1 cycle with act_ready, WAIT ≥1, RESP).
- Rejects respond in 1 cycle.

Other rules:
- act_done outside WAIT is ignored.
- st_color and rt_color are sampled only at acceptance.
- Only one operation is in flight at a time.

Optional Feature:
Macro TIMEOUT_RETRY_EN.
- Defined: on the first timeout of an operation, return to ISSUE and reissue the identical command once with the counter cleared. Status 11 is reported only if the retry also times out. A retry flag is cleared on each new acceptance.
- Undefined: the first timeout goes directly to RESP with status 11.

Test Plan:
1. Reset, then store R, G, B back-to-back; actuator returns act_ready immediately and act_done 2 cycles later → slots 0/1/2 targeted with op=0; pos1=01, pos2=10, pos3=11; three rsp_valid pulses with status 00.
2. Bay full (01,10,11), store G → no act_cmd_valid; rsp_valid one cycle after acceptance, status 01. Then store color 00 → status 01.
3. pos1=01, pos2=10, pos3=00: retrieve G → op=1, slot=1, pos2=00 after act_done, status 00. Then retrieve B → status 10, no command.
4. st_valid and rt_valid held high together from reset (store B, retrieve B) → grant order is store, retrieve, store, ...; each response appears before the next grant.
5. MOVE_TIMEOUT=4, act_done never asserted → status 11 at 4 WAIT cycles, slots unchanged. With TIMEOUT_RETRY_EN: second command issued, status 11 after 8 WAIT cycles.
6. Assert rst while in WAIT with pos1=01 → next cycle: all pos = 00, busy = 0, act_cmd_valid = 0, no rsp_valid; a late act_done is ignored.
